instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Encoder side of the 5-bit-opcode ISA: packs field-level requests (opcode, Rs/Rt/Rd, func, imm) into
//  16-bit instruction words and streams them into instruction memory from a programmable base address.
//  Feeds program images to the fetch/decode path from a test or boot loader.
//  Detects illegal opcodes and out-of-range immediates. Stops cleanly after encoding HALT.
// PARAMETERS
//  ADDR_W  16  instruction-memory byte-address width; each word advances the address by 2
//  CNT_W   12  width of the words-written counter
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse; loads base_addr, clears count/err, enters RUN
//  base_addr   in   ADDR_W  first write address; bit 0 ignored (forced 0)
//  in_valid    in   1       request valid
//  in_ready    out  1       request accepted when in_valid & in_ready
//  in_opcode   in   5       instruction opcode
//  in_rs       in   3       Rs field (destination for LBI/SLBI)
//  in_rt       in   3       Rt field (R-format only)
//  in_rd       in   3       Rd field
//  in_func     in   2       R-format function bits
//  in_imm      in   16      immediate/displacement, two's complement
//  mem_wr_en   out  1       memory write strobe, held until mem_ready
//  mem_addr    out  ADDR_W  write address
//  mem_data    out  16      encoded instruction word
//  mem_ready   in   1       memory accepts write this cycle
//  done        out  1       HALT word written
//  err         out  1       encoding error latched
//  err_code    out  2       01 illegal opcode, 10 imm range, 11 count overflow
//  count       out  CNT_W   words written since start
// BEHAVIOUR
//  Reset: state IDLE; in_ready, mem_wr_en, done, err = 0; err_code, count, mem_addr, mem_data = 0.
//  States: IDLE -start-> RUN; RUN -HALT word written-> DONE; RUN -error-> ERR; DONE/ERR -start-> RUN.
//   start in RUN is ignored. start and in_valid in the same cycle: start takes effect, and the request is not accepted.
//  in_ready = (state==RUN) & ~halt_seen & (~mem_wr_en | mem_ready).
//  Accept cycle N: the word is registered, and mem_wr_en=1 with addr/data from cycle N+1. Data/addr hold stable while mem_ready=0.
//  On mem_ready & mem_wr_en: mem_addr += 2 (wraps mod 2^ADDR_W, silently), count += 1. Full throughput with mem_ready stuck at 1.
//  Formats ([15:11]=opcode always):
//   J   00100 J, 00110 JAL: [10:0]=imm, signed -1024..1023
//   I2  011xx branches, 11000 LBI, 00101 JR, 00111 JALR: [10:8]=rs, [7:0]=imm, signed -128..127
//       10010 SLBI: same fields, unsigned 0..255
//   I1  01000 ADDI, 01001 SUBI, 10000 ST, 10001 LD, 10011 STU: [10:8]=rs, [7:5]=rd, [4:0]=imm, signed -16..15
//       01010 XORI, 01011 ANDNI: unsigned 0..31; 101xx shifts/rotates: unsigned 0..15
//   R   1101x, 111xx: [10:8]=rs, [7:5]=rt, [4:2]=rd, [1:0]=func
//       11001 BTR: rt and func forced to 0
//   00000 HALT, 00001 NOP: [10:0]=0
//  Illegal opcodes 00010, 00011: no write; ERR, err_code=01, in the cycle after acceptance.
//  Immediate out of range: no write; ERR, err_code=10.
//  A word that would push count past 2^CNT_W-1: not written; ERR, err_code=11.
//  HALT accepted: in_ready drops the next cycle. DONE and done=1 start the cycle after its write completes.
//  rst mid-write: the pending write is dropped and all outputs return to their reset values.
// CONFIGURATION
//  RANGE_CHECK_EN defined: immediate range checks active (err_code 10).
//  RANGE_CHECK_EN undefined: immediates silently truncated to field width, and err_code 10 is never raised.
// TESTING
//  start base=0x0100; ADDI rs=1 rd=2 imm=-3 -> write 0x415D @0x0100, count=1
//  LBI rs=3 imm=0x7F; ADD rs=1 rt=2 rd=3 func=0, back-to-back -> 0xC37F @0x0100, 0xD94C @0x0102, in_ready held 1
//  J imm=-2 with mem_ready low 3 cycles -> 0x27FE held stable 3 cycles, then count increments once
//  ADDI imm=16 (RANGE_CHECK_EN) -> no write, err=1, err_code=10; the same input without the macro -> 0x4150 written
//  opcode 00010 -> err_code=01, in_ready=0, no mem_wr_en; then start -> err cleared, RUN
//  NOP, HALT -> 0x0800, 0x0000 written, done=1, in_ready=0; base=0xFFFE with two words -> second at 0x0000

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs field-level instruction requests (opcode, rs/rt/rd, func, imm) into
// 16-bit words of the 5-bit-opcode ISA. The words are streamed into instruction
// memory starting at a programmable base address, one 16-bit word per 2-byte
// step. The block flags illegal opcodes, out-of-range immediates and counter
// overflow, and stops cleanly once the HALT word has been written.
//
// Compile-time option:
//   RANGE_CHECK_EN  defined   -> immediates are range-checked and err_code 10
//                                is raised when a value does not fit its field.
//                   undefined -> immediates are truncated to the field width and
//                                err_code 10 is never raised.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   start      1-cycle pulse: load base_addr, clear count/err, enter RUN
//              (ignored while in RUN)
//   base_addr  first write address; bit 0 is forced to 0
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready
//   in_opcode  5-bit opcode
//   in_rs      Rs field (destination register for LBI/SLBI)
//   in_rt      Rt field (R-format only)
//   in_rd      Rd field
//   in_func    R-format function bits
//   in_imm     immediate / displacement, two's complement
//   mem_wr_en  write strobe, held with stable addr/data until mem_ready
//   mem_addr   write byte address
//   mem_data   encoded instruction word
//   mem_ready  memory accepts the write this cycle
//   done       HALT word has been written
//   err        encoding error latched
//   err_code   01 illegal opcode, 10 immediate range, 11 count overflow
//   count      words written since start
// -----------------------------------------------------------------------------
// State table
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | after reset, waiting for start
//   S_RUN   | accepting requests and writing words
//   S_DONE  | HALT word written; waiting for start
//   S_ERR   | encoding error latched in err_code; waiting for start
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_rd,
    input  logic [1:0]        in_func,
    input  logic [15:0]       in_imm,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    input  logic              mem_ready,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Word layout family selected by the opcode.
    typedef enum logic [2:0] {
        FMT_Z  = 3'd0,   // HALT / NOP: operand bits all zero
        FMT_J  = 3'd1,   // [10:0] = imm
        FMT_I2 = 3'd2,   // [10:8] = rs, [7:0] = imm
        FMT_I1 = 3'd3,   // [10:8] = rs, [7:5] = rd, [4:0] = imm
        FMT_R  = 3'd4    // [10:8] = rs, [7:5] = rt, [4:2] = rd, [1:0] = func
    } fmt_t;

    // Legal immediate range for the selected opcode.
    typedef enum logic [2:0] {
        RC_NONE = 3'd0,
        RC_S11  = 3'd1,  // -1024..1023
        RC_S8   = 3'd2,  // -128..127
        RC_U8   = 3'd3,  // 0..255
        RC_S5   = 3'd4,  // -16..15
        RC_U5   = 3'd5,  // 0..31
        RC_U4   = 3'd6   // 0..15
    } rc_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_COUNT   = 2'b11;

    state_t         state;
    state_t         state_nxt;
    logic           halt_seen;

    fmt_t           fmt;
    rc_t            rc;
    logic           illegal;
    logic           is_btr;
    logic           is_halt;
    logic           imm_ok;
    logic           range_bad;
    logic           cnt_full;
    logic [1:0]     enc_code;
    logic           enc_err;
    logic [15:0]    word;
    logic [CNT_W:0] cnt_commit;
    logic           accept;
    logic           wr_done;
    logic           start_ok;
    logic           unused_bits;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // A new request may be taken while the previous write completes in the
    // same cycle, which gives one word per clock with mem_ready held high.
    assign in_ready = (state == S_RUN) & ~halt_seen & (~mem_wr_en | mem_ready);
    assign accept   = in_valid & in_ready;
    assign wr_done  = mem_wr_en & mem_ready;
    assign start_ok = start & (state != S_RUN);

    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    always_comb begin
        fmt     = FMT_R;
        rc      = RC_NONE;
        illegal = 1'b0;
        casez (in_opcode)
            5'b0000?: fmt = FMT_Z;
            5'b0001?: begin
                fmt     = FMT_Z;
                illegal = 1'b1;
            end
            5'b00100, 5'b00110: begin
                fmt = FMT_J;
                rc  = RC_S11;
            end
            5'b00101, 5'b00111, 5'b011??, 5'b11000: begin
                fmt = FMT_I2;
                rc  = RC_S8;
            end
            5'b10010: begin
                fmt = FMT_I2;
                rc  = RC_U8;
            end
            5'b0100?, 5'b10000, 5'b10001, 5'b10011: begin
                fmt = FMT_I1;
                rc  = RC_S5;
            end
            5'b0101?: begin
                fmt = FMT_I1;
                rc  = RC_U5;
            end
            5'b101??: begin
                fmt = FMT_I1;
                rc  = RC_U4;
            end
            default: begin
                // 11001 (BTR), 1101x, 111xx
                fmt = FMT_R;
                rc  = RC_NONE;
            end
        endcase
    end

    assign is_btr  = (in_opcode == 5'b11001);
    assign is_halt = (in_opcode == 5'b00000);

    // ------------------------------------------------------------------
    // Immediate range check
    // ------------------------------------------------------------------
    // Signed fields fit when every bit above the field's sign bit matches it;
    // unsigned fields fit when every bit above the field is zero.
    always_comb begin
        imm_ok = 1'b1;
        case (rc)
            RC_S11:  imm_ok = (in_imm[15:10] == 6'h00)  || (in_imm[15:10] == 6'h3F);
            RC_S8:   imm_ok = (in_imm[15:7]  == 9'h000) || (in_imm[15:7]  == 9'h1FF);
            RC_U8:   imm_ok = (in_imm[15:8]  == 8'h00);
            RC_S5:   imm_ok = (in_imm[15:4]  == 12'h000) || (in_imm[15:4] == 12'hFFF);
            RC_U5:   imm_ok = (in_imm[15:5]  == 11'h000);
            RC_U4:   imm_ok = (in_imm[15:4]  == 12'h000);
            default: imm_ok = 1'b1;
        endcase
    end

`ifdef RANGE_CHECK_EN
    assign range_bad   = ~imm_ok;
    assign unused_bits = base_addr[0];
`else
    assign range_bad   = 1'b0;
    assign unused_bits = base_addr[0] ^ imm_ok;
`endif

    // ------------------------------------------------------------------
    // Count overflow guard
    // ------------------------------------------------------------------
    // Any write still pending at acceptance completes in the same cycle, so
    // it is already committed. The new word is refused if it would take the
    // counter beyond its all-ones value.
    assign cnt_commit = {1'b0, count} + {{CNT_W{1'b0}}, mem_wr_en};
    assign cnt_full   = (cnt_commit >= {1'b0, {CNT_W{1'b1}}});

    always_comb begin
        enc_code = ERR_NONE;
        if (illegal) begin
            enc_code = ERR_ILLEGAL;
        end else if (range_bad) begin
            enc_code = ERR_RANGE;
        end else if (cnt_full) begin
            enc_code = ERR_COUNT;
        end
    end

    assign enc_err = (enc_code != ERR_NONE);

    // ------------------------------------------------------------------
    // Word packing
    // ------------------------------------------------------------------
    always_comb begin
        word = {in_opcode, 11'b0};
        case (fmt)
            FMT_J:   word[10:0] = in_imm[10:0];
            FMT_I2:  word[10:0] = {in_rs, in_imm[7:0]};
            FMT_I1:  word[10:0] = {in_rs, in_rd, in_imm[4:0]};
            FMT_R: begin
                if (is_btr) begin
                    word[10:0] = {in_rs, 3'b000, in_rd, 2'b00};
                end else begin
                    word[10:0] = {in_rs, in_rt, in_rd, in_func};
                end
            end
            default: word[10:0] = 11'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && enc_err) begin
                    state_nxt = S_ERR;
                end else if (wr_done && halt_seen) begin
                    // the only write outstanding after HALT is HALT itself
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            count     <= '0;
            err_code  <= ERR_NONE;
            halt_seen <= 1'b0;
        end else if (start_ok) begin
            mem_wr_en <= 1'b0;
            mem_addr  <= {base_addr[ADDR_W-1:1], 1'b0};
            count     <= '0;
            err_code  <= ERR_NONE;
            halt_seen <= 1'b0;
        end else begin
            if (wr_done) begin
                mem_wr_en <= 1'b0;
                mem_addr  <= mem_addr + ADDR_W'(2);
                count     <= count + CNT_W'(1);
            end
            if (accept) begin
                if (enc_err) begin
                    err_code <= enc_code;
                end else begin
                    mem_wr_en <= 1'b1;
                    mem_data  <= word;
                    if (is_halt) begin
                        halt_seen <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 12;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [2:0]        in_rs;
    logic [2:0]        in_rt;
    logic [2:0]        in_rd;
    logic [1:0]        in_func;
    logic [15:0]       in_imm;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_ready;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [CNT_W-1:0]  count;

    instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_func   (in_func),
        .in_imm    (in_imm),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_addr;
    logic [31:0] mon_exp;

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [1:0]  func;
        logic [15:0] imm;
        logic [15:0] word;
    } vec_t;

    // Scoreboard: every completed write is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && mem_wr_en && mem_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr, mem_data} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_data, mon_exp[31:16], mon_exp[15:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] base);
        start     = 1'b1;
        base_addr = base;
        exp_addr  = {base[15:1], 1'b0};
        tick();
        start     = 1'b0;
    endtask

    task automatic push_req(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                            input logic [2:0] rd, input logic [1:0] func, input logic [15:0] imm,
                            input bit exp_wr, input logic [15:0] exp_word, output int lat);
        bit took;
        bit ok;
        ok  = 1'b0;
        lat = 0;
        if (exp_wr) begin
            exp_q.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + 16'd2;
        end
        in_valid  = 1'b1;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_func   = func;
        in_imm    = imm;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            took = in_ready;
            tick();
            if (took) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no acceptance of opcode %b, required acceptance within 50 cycles", op);
            if (exp_wr) void'(exp_q.pop_back());
        end
    endtask

    task automatic wait_drain();
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !mem_wr_en) begin
                drained = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if (!drained) begin
            miscompares++;
            $display("FAIL drain: got %0d writes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({in_ready, mem_wr_en, done, err, err_code} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy=%b wr=%b done=%b err=%b code=%b, required all 0",
                     in_ready, mem_wr_en, done, err, err_code);
        end
        vectors++;
        if ({count, mem_addr, mem_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: got count=%h addr=%h data=%h, required 0", count, mem_addr, mem_data);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: got %b, required 0", in_ready);
        end
    endtask

    task automatic test_addi();
        int lat;
        reset_dut();
        do_start(16'h0100);
        push_req(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, -16'sd3, 1'b1, 16'h415D, lat);
        wait_drain();
        vectors++;
        if (count !== 12'd1) begin
            miscompares++;
            $display("FAIL addi_count: got %0d, required 1", count);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        reset_dut();
        do_start(16'h0100);
        push_req(5'b11000, 3'd3, 3'd0, 3'd0, 2'd0, 16'h007F, 1'b1, 16'hC37F, lat);
        push_req(5'b11011, 3'd1, 3'd2, 3'd3, 2'd0, 16'h0000, 1'b1, 16'hD94C, lat);
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d cycles, required 1", lat);
        end
        wait_drain();
        vectors++;
        if (count !== 12'd2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d, required 2", count);
        end
    endtask

    task automatic test_formats();
        vec_t tab [10];
        int   lat;
        tab[0] = '{5'b10010, 3'd2, 3'd0, 3'd0, 2'd0, 16'h00FF, 16'h92FF};
        tab[1] = '{5'b11001, 3'd1, 3'd7, 3'd2, 2'd3, 16'hFFFF, 16'hC908};
        tab[2] = '{5'b10100, 3'd1, 3'd0, 3'd1, 2'd0, 16'h000F, 16'hA12F};
        tab[3] = '{5'b00110, 3'd0, 3'd0, 3'd0, 2'd0, 16'h03FF, 16'h33FF};
        tab[4] = '{5'b01100, 3'd5, 3'd0, 3'd0, 2'd0, 16'hFF80, 16'h6580};
        tab[5] = '{5'b01010, 3'd7, 3'd0, 3'd0, 2'd0, 16'h001F, 16'h571F};
        tab[6] = '{5'b10000, 3'd2, 3'd0, 3'd6, 2'd0, 16'hFFF0, 16'h82D0};
        tab[7] = '{5'b11100, 3'd7, 3'd6, 3'd5, 2'd2, 16'h0000, 16'hE7D6};
        tab[8] = '{5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFC00, 16'h2400};
        tab[9] = '{5'b00111, 3'd4, 3'd0, 3'd0, 2'd0, 16'h007F, 16'h3C7F};
        reset_dut();
        do_start(16'h0400);
        foreach (tab[i]) begin
            push_req(tab[i].op, tab[i].rs, tab[i].rt, tab[i].rd, tab[i].func, tab[i].imm,
                     1'b1, tab[i].word, lat);
        end
        wait_drain();
        vectors++;
        if (count !== 12'd10) begin
            miscompares++;
            $display("FAIL formats_count: got %0d, required 10", count);
        end
    endtask

    task automatic test_stall();
        int lat;
        reset_dut();
        do_start(16'h0200);
        mem_ready = 1'b0;
        push_req(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFFE, 1'b1, 16'h27FE, lat);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({mem_wr_en, mem_addr, mem_data, count} !== {1'b1, 16'h0200, 16'h27FE, 12'd0}) begin
                miscompares++;
                $display("FAIL stall_hold: cycle %0d got wr=%b addr=%h data=%h count=%0d, required wr=1 addr=0200 data=27FE count=0",
                         i, mem_wr_en, mem_addr, mem_data, count);
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        vectors++;
        if ({mem_wr_en, count} !== {1'b0, 12'd1}) begin
            miscompares++;
            $display("FAIL stall_release: got wr=%b count=%0d, required wr=0 count=1", mem_wr_en, count);
        end
        wait_drain();
    endtask

    task automatic test_range();
        int lat;
        reset_dut();
        do_start(16'h0500);
        push_req(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'h000F, 1'b1, 16'h414F, lat);
        push_req(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'hFFF0, 1'b1, 16'h4150, lat);
`ifdef RANGE_CHECK_EN
        push_req(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'h0010, 1'b0, 16'h0000, lat);
        vectors++;
        if ({err, err_code, in_ready} !== 4'b1100) begin
            miscompares++;
            $display("FAIL range_err: got err=%b code=%b rdy=%b, required err=1 code=10 rdy=0", err, err_code, in_ready);
        end
`else
        push_req(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'h0010, 1'b1, 16'h4150, lat);
        vectors++;
        if ({err, err_code} !== 3'b000) begin
            miscompares++;
            $display("FAIL range_trunc: got err=%b code=%b, required err=0 code=00", err, err_code);
        end
`endif
        wait_drain();
    endtask

    task automatic test_illegal();
        int lat;
        reset_dut();
        do_start(16'h0080);
        push_req(5'b00010, 3'd1, 3'd1, 3'd1, 2'd1, 16'h0001, 1'b0, 16'h0000, lat);
        vectors++;
        if ({err, err_code, in_ready, mem_wr_en} !== 5'b10100) begin
            miscompares++;
            $display("FAIL illegal_err: got err=%b code=%b rdy=%b wr=%b, required err=1 code=01 rdy=0 wr=0",
                     err, err_code, in_ready, mem_wr_en);
        end
        tick();
        tick();
        vectors++;
        if ({mem_wr_en, count} !== {1'b0, 12'd0}) begin
            miscompares++;
            $display("FAIL illegal_nowrite: got wr=%b count=%0d, required wr=0 count=0", mem_wr_en, count);
        end
        do_start(16'h0080);
        vectors++;
        if ({err, err_code, in_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL illegal_restart: got err=%b code=%b rdy=%b, required err=0 code=00 rdy=1", err, err_code, in_ready);
        end
    endtask

    task automatic test_halt();
        int  lat;
        bit  seen;
        reset_dut();
        do_start(16'h0300);
        push_req(5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1, 16'h0800, lat);
        push_req(5'b00000, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1, 16'h0000, lat);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_ready: got %b, required 0 after HALT accepted", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if ({seen, done, in_ready, err, count} !== {1'b1, 1'b1, 1'b0, 1'b0, 12'd2}) begin
            miscompares++;
            $display("FAIL halt_done: got done=%b rdy=%b err=%b count=%0d, required done=1 rdy=0 err=0 count=2",
                     done, in_ready, err, count);
        end
        wait_drain();
    endtask

    task automatic test_wrap();
        int lat;
        do_start(16'hFFFF);
        vectors++;
        if ({done, in_ready, mem_addr} !== {1'b0, 1'b1, 16'hFFFE}) begin
            miscompares++;
            $display("FAIL wrap_start: got done=%b rdy=%b addr=%h, required done=0 rdy=1 addr=FFFE", done, in_ready, mem_addr);
        end
        push_req(5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1, 16'h0800, lat);
        push_req(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'hFFFD, 1'b1, 16'h415D, lat);
        wait_drain();
        vectors++;
        if ({mem_addr, count} !== {16'h0002, 12'd2}) begin
            miscompares++;
            $display("FAIL wrap_end: got addr=%h count=%0d, required addr=0002 count=2", mem_addr, count);
        end
    endtask

    task automatic test_midwrite_reset();
        int lat;
        reset_dut();
        do_start(16'h0040);
        mem_ready = 1'b0;
        push_req(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0005, 1'b0, 16'h0000, lat);
        vectors++;
        if (mem_wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pending: got wr=%b, required 1", mem_wr_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({mem_wr_en, in_ready, done, err, err_code, count, mem_addr, mem_data} !== '0) begin
            miscompares++;
            $display("FAIL midrst_regs: got wr=%b rdy=%b addr=%h data=%h count=%0d, required all 0",
                     mem_wr_en, in_ready, mem_addr, mem_data, count);
        end
        mem_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if (mem_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_dropped: got wr=%b, required 0", mem_wr_en);
        end
    endtask

    task automatic test_overflow();
        int lat;
        reset_dut();
        do_start(16'h0000);
        for (int i = 0; i < 4095; i++) begin
            push_req(5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1, 16'h0800, lat);
        end
        push_req(5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b0, 16'h0000, lat);
        vectors++;
        if ({err, err_code, count} !== {1'b1, 2'b11, 12'hFFF}) begin
            miscompares++;
            $display("FAIL overflow: got err=%b code=%b count=%0d, required err=1 code=11 count=4095", err, err_code, count);
        end
        wait_drain();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_func   = '0;
        in_imm    = '0;
        mem_ready = 1'b1;
        exp_addr  = '0;
        #1;
        test_reset();
        test_addi();
        test_back_to_back();
        test_formats();
        test_stall();
        test_range();
        test_illegal();
        test_halt();
        test_wrap();
        test_midwrite_reset();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
